// File: rtl/hvac_pkg.sv
// rtl/hvac_pkg.sv - shared state type, default constants and zone index width helper
package hvac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAT = 2'd1,
    ST_COOL = 2'd2,
    ST_LOCK = 2'd3
  } hvac_state_t;

  localparam int DEF_NZONES  = 4;
  localparam int DEF_TEMP_W  = 5;
  localparam int DEF_HEAT_ON = 18;
  localparam int DEF_COOL_ON = 22;
  localparam int DEF_TARGET  = 20;
  localparam int DEF_MIN_ON  = 8;
  localparam int DEF_LOCKOUT = 4;
  localparam int DEF_MAX_ON  = 32;

  function automatic int zone_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hvac_rr_arbiter.sv
// rtl/hvac_rr_arbiter.sv - combinational round-robin pick of the first requesting zone
// Search starts at i_ptr and wraps; o_idx is the binary index of the one-hot o_grant.
module hvac_rr_arbiter
  import hvac_pkg::*;
#(
  parameter int NZONES = DEF_NZONES,
  localparam int IW    = zone_idx_w(NZONES)
) (
  input  logic [NZONES-1:0] i_req,
  input  logic [IW-1:0]     i_ptr,
  output logic [NZONES-1:0] o_grant,
  output logic [IW-1:0]     o_idx,
  output logic              o_valid
);

  always_comb begin : search
    int z;
    z       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NZONES; k++) begin
      z = int'(i_ptr) + k;
      if (z >= NZONES) z = z - NZONES;
      if (!o_valid && i_req[z]) begin
        o_valid    = 1'b1;
        o_grant[z] = 1'b1;
        o_idx      = IW'(z);
      end
    end
  end

endmodule

// File: rtl/hvac_zone_scheduler.sv
// rtl/hvac_zone_scheduler.sv - shares one heat/cool plant among zones with hysteresis, min-on and lockout
// Optional fairness release after MAX_ON cycles is enabled by defining HVAC_FAIR_EN.
module hvac_zone_scheduler
  import hvac_pkg::*;
#(
  parameter int NZONES  = DEF_NZONES,
  parameter int TEMP_W  = DEF_TEMP_W,
  parameter int HEAT_ON = DEF_HEAT_ON,
  parameter int COOL_ON = DEF_COOL_ON,
  parameter int TARGET  = DEF_TARGET,
  parameter int MIN_ON  = DEF_MIN_ON,
  parameter int LOCKOUT = DEF_LOCKOUT,
  parameter int MAX_ON  = DEF_MAX_ON
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NZONES*TEMP_W-1:0] i_temperature,
  input  logic [NZONES-1:0]        i_zone_en,
  output logic                     o_heating,
  output logic                     o_cooling,
  output logic [NZONES-1:0]        o_zone_valve,
  output logic                     o_busy
);

  localparam int IW      = zone_idx_w(NZONES);
  localparam int CNT_MAX = (MAX_ON > MIN_ON) ? MAX_ON : MIN_ON;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LK_W    = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;

  localparam logic [TEMP_W-1:0] L_HEAT_ON = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] L_COOL_ON = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] L_TARGET  = TEMP_W'(TARGET);

  hvac_state_t       r_state, w_next;
  logic [CNT_W-1:0]  r_on_cnt, w_on_cnt;
  logic [LK_W-1:0]   r_lock_cnt, w_lock_cnt;
  logic [IW-1:0]     r_ptr, w_ptr, r_idx, w_idx;
  logic [NZONES-1:0] w_hreq, w_creq, w_req, w_grant;
  logic [IW-1:0]     w_gidx;
  logic              w_gvalid;
  logic [TEMP_W-1:0] w_temp_g;
  logic              w_satisfied, w_fair, w_release;

  always_comb begin
    w_hreq   = '0;
    w_creq   = '0;
    w_temp_g = '0;
    for (int i = 0; i < NZONES; i++) begin
      w_hreq[i] = i_zone_en[i] & (i_temperature[i*TEMP_W +: TEMP_W] <= L_HEAT_ON);
      w_creq[i] = i_zone_en[i] & (i_temperature[i*TEMP_W +: TEMP_W] >= L_COOL_ON);
      if (IW'(i) == r_idx) w_temp_g = i_temperature[i*TEMP_W +: TEMP_W];
    end
  end

  assign w_req = w_hreq | w_creq;

  hvac_rr_arbiter #(.NZONES(NZONES)) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_valid (w_gvalid)
  );

  assign w_satisfied = (r_state == ST_HEAT) ? (w_temp_g >= L_TARGET) : (w_temp_g <= L_TARGET);

  // The served zone's valve bit masks it out of the "someone else is waiting" test.
`ifdef HVAC_FAIR_EN
  assign w_fair = (r_on_cnt >= CNT_W'(MAX_ON - 1)) && (|(w_req & ~o_zone_valve));
`else
  assign w_fair = 1'b0;
`endif

  assign w_release = (w_satisfied && (r_on_cnt >= CNT_W'(MIN_ON - 1))) || !i_zone_en[r_idx] || w_fair;

  always_comb begin
    w_next     = r_state;
    w_on_cnt   = r_on_cnt;
    w_lock_cnt = r_lock_cnt;
    w_ptr      = r_ptr;
    w_idx      = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_gvalid) begin
          w_next   = (|(w_hreq & w_grant)) ? ST_HEAT : ST_COOL;
          w_idx    = w_gidx;
          w_on_cnt = '0;
          w_ptr    = (w_gidx == IW'(NZONES - 1)) ? '0 : w_gidx + IW'(1);
        end
      end
      ST_HEAT, ST_COOL: begin
        if (r_on_cnt != {CNT_W{1'b1}}) w_on_cnt = r_on_cnt + CNT_W'(1);
        if (w_release) begin
          w_next     = ST_LOCK;
          w_lock_cnt = '0;
        end
      end
      ST_LOCK: begin
        if (r_lock_cnt == LK_W'(LOCKOUT - 1)) w_next = ST_IDLE;
        else w_lock_cnt = r_lock_cnt + LK_W'(1);
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_on_cnt     <= '0;
      r_lock_cnt   <= '0;
      r_ptr        <= '0;
      r_idx        <= '0;
      o_heating    <= 1'b0;
      o_cooling    <= 1'b0;
      o_zone_valve <= '0;
      o_busy       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_on_cnt     <= w_on_cnt;
      r_lock_cnt   <= w_lock_cnt;
      r_ptr        <= w_ptr;
      r_idx        <= w_idx;
      o_heating    <= (w_next == ST_HEAT);
      o_cooling    <= (w_next == ST_COOL);
      o_zone_valve <= (w_next == ST_HEAT || w_next == ST_COOL) ? (NZONES'(1) << w_idx) : '0;
      o_busy       <= (w_next != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// tb/tb_hvac_zone_scheduler.sv - scoreboard bench for the zone scheduler
// Builds with or without HVAC_FAIR_EN; expectations follow the macro.
module tb_hvac_zone_scheduler;

  localparam logic [6:0] PAT_IDLE = 7'b0_00_0000;
  localparam logic [6:0] PAT_LOCK = 7'b1_00_0000;
  localparam logic [6:0] PAT_HZ0  = 7'b1_10_0001;
  localparam logic [6:0] PAT_HZ1  = 7'b1_10_0010;
  localparam logic [6:0] PAT_CZ2  = 7'b1_01_0100;
  localparam logic [6:0] PAT_CZ3  = 7'b1_01_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] temps;
  logic [3:0]  zone_en;
  logic        heating, cooling, busy;
  logic [3:0]  zone_valve;
  logic [6:0]  w_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] sb_q[$];

  always #5 clk = ~clk;

  hvac_zone_scheduler dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_temperature (temps),
    .i_zone_en     (zone_en),
    .o_heating     (heating),
    .o_cooling     (cooling),
    .o_zone_valve  (zone_valve),
    .o_busy        (busy)
  );

  assign w_out = {busy, heating, cooling, zone_valve};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: decides the next outputs from the inputs seen at each edge.
  int m_state = 0, m_on = 0, m_lock = 0, m_ptr = 0, m_g = 0;
  always @(posedge clk) begin : model
    logic [3:0] hr, cr;
    int tz, tg;
    logic found, sat, other, rel;
    for (int z = 0; z < 4; z++) begin
      tz    = int'(temps[z*5 +: 5]);
      hr[z] = zone_en[z] && (tz <= 18);
      cr[z] = zone_en[z] && (tz >= 22);
    end
    if (!rst_n) begin
      m_state = 0; m_on = 0; m_lock = 0; m_ptr = 0; m_g = 0;
    end else if (m_state == 0) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        tz = (m_ptr + k) % 4;
        if (!found && (hr[tz] || cr[tz])) begin
          found = 1'b1;
          m_g   = tz;
        end
      end
      if (found) begin
        m_state = hr[m_g] ? 1 : 2;
        m_on    = 0;
        m_ptr   = (m_g + 1) % 4;
      end
    end else if (m_state == 3) begin
      if (m_lock == 3) m_state = 0;
      else m_lock++;
    end else begin
      tg    = int'(temps[m_g*5 +: 5]);
      sat   = (m_state == 1) ? (tg >= 20) : (tg <= 20);
      other = 1'b0;
      for (int z = 0; z < 4; z++) if (z != m_g && (hr[z] || cr[z])) other = 1'b1;
      rel = (sat && m_on >= 7) || !zone_en[m_g];
`ifdef HVAC_FAIR_EN
      if (m_on >= 31 && other) rel = 1'b1;
`endif
      if (m_on < 255) m_on++;
      if (rel) begin
        m_state = 3;
        m_lock  = 0;
      end
    end
    sb_q.push_back({m_state != 0, m_state == 1, m_state == 2,
                    (m_state == 1 || m_state == 2) ? 4'(1 << m_g) : 4'b0000});
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) check_val("sb_outputs", w_out, sb_q.pop_front());
  end

  task automatic set_temp(input int z, input int v);
    temps[z*5 +: 5] = 5'(v);
  endtask

  task automatic run_len(input logic [6:0] pat, input int limit, output int n);
    n = 0;
    while (w_out === pat && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    rst_n   = 1'b0;
    zone_en = 4'hF;
    temps   = {4{5'd20}};
    repeat (3) @(negedge clk);
    check_val("reset_state", w_out, PAT_IDLE);
    rst_n = 1'b1;

    // all zones comfortable: nothing happens
    repeat (10) @(negedge clk);
    check_val("s1_idle", w_out, PAT_IDLE);

    // heat z0 and cool z2 contend; rr order decides
    set_temp(0, 16); set_temp(2, 25);
    @(negedge clk);
    check_val("s3_heat_z0", w_out, PAT_HZ0);
    set_temp(0, 20);
    run_len(PAT_HZ0, 100, n);  check_val("s3_heat_len", n, 8);
    run_len(PAT_LOCK, 20, n);  check_val("s3_lock_len", n, 4);
    check_val("s3_gap", w_out, PAT_IDLE);
    @(negedge clk);
    check_val("s3_cool_z2", w_out, PAT_CZ2);
    set_temp(0, 16); set_temp(2, 20);
    run_len(PAT_CZ2, 100, n);  check_val("s3_cool_len", n, 8);
    set_temp(2, 25);
    run_len(PAT_LOCK, 20, n);  check_val("s3_lock2_len", n, 4);
    @(negedge clk);
    check_val("s3_z0_again", w_out, PAT_HZ0);
    set_temp(0, 20); set_temp(2, 20);
    run_len(PAT_HZ0, 100, n);  check_val("s3_heat2_len", n, 8);
    run_len(PAT_LOCK, 20, n);

    // single heat request, satisfied early, held to the minimum on-time
    set_temp(1, 16);
    @(negedge clk);
    check_val("s2_grant", w_out, PAT_HZ1);
    @(negedge clk);
    set_temp(1, 21);
    run_len(PAT_HZ1, 100, n);  check_val("s2_heat_len", n + 1, 8);
    run_len(PAT_LOCK, 20, n);  check_val("s2_lock_len", n, 4);
    check_val("s2_idle", w_out, PAT_IDLE);

    // disabling the served zone releases at once; demand during lock is deferred
    set_temp(3, 28);
    @(negedge clk);
    check_val("s4_cool_z3", w_out, PAT_CZ3);
    @(negedge clk);
    @(negedge clk);
    zone_en = 4'b0111;
    @(negedge clk);
    check_val("s4_lock", w_out, PAT_LOCK);
    zone_en = 4'hF; set_temp(3, 20); set_temp(1, 16);
    run_len(PAT_LOCK, 20, n);  check_val("s4_lock_len", n, 4);
    check_val("s4_idle", w_out, PAT_IDLE);
    @(negedge clk);
    check_val("s4_z1", w_out, PAT_HZ1);
    set_temp(1, 21);
    run_len(PAT_HZ1, 100, n);  check_val("s4_heat_len", n, 8);
    run_len(PAT_LOCK, 20, n);

    // two zones never satisfied: fairness release only with the macro
    set_temp(0, 10); set_temp(1, 10);
    @(negedge clk);
    check_val("s5_heat_z0", w_out, PAT_HZ0);
`ifdef HVAC_FAIR_EN
    run_len(PAT_HZ0, 200, n);  check_val("s5_fair_len", n, 32);
    run_len(PAT_LOCK, 20, n);  check_val("s5_lock_len", n, 4);
    check_val("s5_gap", w_out, PAT_IDLE);
    @(negedge clk);
    check_val("s5_z1", w_out, PAT_HZ1);
    set_temp(0, 20); set_temp(1, 21);
    run_len(PAT_HZ1, 100, n);  check_val("s5_z1_len", n, 8);
`else
    run_len(PAT_HZ0, 60, n);   check_val("s5_hold_len", n, 60);
    set_temp(0, 20); set_temp(1, 20);
    run_len(PAT_HZ0, 100, n);  check_val("s5_release", n, 1);
`endif
    run_len(PAT_LOCK, 20, n);  check_val("s5_end_lock", n, 4);

    // reset mid-heat clears outputs and the rr pointer
    set_temp(1, 16);
    @(negedge clk);
    check_val("s6_heat_z1", w_out, PAT_HZ1);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("s6_reset_out", w_out, PAT_IDLE);
    rst_n = 1'b1;
    set_temp(1, 20); set_temp(0, 16); set_temp(2, 16);
    @(negedge clk);
    check_val("s6_ptr0", w_out, PAT_HZ0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
